instr_encoder: RTL and testbench

- Inverse of the ariane decoder for the RV64 subset the decoder property set covers: integer R-type ALU, M-extension, loads and stores.
- Takes a scoreboard-style request (fu, op, rs1, rs2, rd, imm) and produces the 32-bit instruction word.
- Encoded words are buffered in a small FIFO with valid/ready handshakes on both sides.
- Used in the formal/sim environment to drive decoder instruction_i for round-trip checks (encode -> decode -> compare fields), and as a reusable stimulus source.

---
 rtl/instr_enc_pkg.sv | 31 +++
 rtl/instr_enc_fifo.sv | 64 ++++++
 rtl/instr_encoder.sv | 172 +++++++++++++++++
 tb/tb_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types and encoding constants for the RV64 instruction encoder.
// fu_t / fu_op mirror the ariane_pkg encodings so requests can be lifted straight from a scoreboard.
package instr_enc_pkg;

    typedef enum logic [3:0] {
        NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
    } fu_t;

    typedef enum logic [6:0] {
        ADD, SUB, ADDW, SUBW, XORL, ORL, ANDL, SRA, SRL, SLL, SRLW, SLLW, SRAW,
        LTS, LTU, GES, GEU, EQ, NE, JALR, BRANCH, SLTS, SLTU,
        MRET, SRET, DRET, ECALL, WFI, FENCE, FENCE_I, SFENCE_VMA,
        CSR_WRITE, CSR_READ, CSR_SET, CSR_CLEAR,
        LD, SD, LW, LWU, SW, LH, LHU, SH, LB, SB, LBU,
        MUL, MULH, MULHU, MULHSU, MULW, DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW
    } fu_op;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef struct packed {
        logic [31:0] instr;
        logic        illegal;
    } enc_entry_t;

endpackage

// File: rtl/instr_enc_fifo.sv
// DEPTH-entry FIFO of encoded words; flush has priority over push and pop.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module instr_enc_fifo
    import instr_enc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush_i,
    input  logic       push_i,
    input  enc_entry_t entry_i,
    input  logic       pop_i,
    output enc_entry_t entry_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    enc_entry_t  mem_q [DEPTH];
    logic        wr_en, rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    // The head reads as zero when empty so the outputs are clean out of reset.
    assign entry_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; pointers alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes scoreboard-style requests into RV64 instruction words (R-type ALU/M, loads, stores).
// Request -> encode -> stage register -> output FIFO, valid/ready on both sides.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  fu_t              req_fu_i,
    input  fu_op             req_op_i,
    input  logic [4:0]       req_rs1_i,
    input  logic [4:0]       req_rs2_i,
    input  logic [4:0]       req_rd_i,
    input  logic [11:0]      req_imm_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [31:0]      instr_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] enc_count_o,
    output logic [CNT_W-1:0] ill_count_o
);

    function automatic enc_entry_t encode(fu_t fu, fu_op op, logic [4:0] rs1, logic [4:0] rs2,
                                          logic [4:0] rd, logic [11:0] imm);
        enc_entry_t e;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       legal;
        opc   = OPC_OP;
        f7    = F7_BASE;
        f3    = 3'b000;
        legal = 1'b1;
        case (fu)
            ALU: begin
                case (op)
                    ADD:  f3 = 3'b000;
                    SUB:  begin f7 = F7_ALT; f3 = 3'b000; end
                    SLL:  f3 = 3'b001;
                    SLTS: f3 = 3'b010;
                    SLTU: f3 = 3'b011;
                    XORL: f3 = 3'b100;
                    SRL:  f3 = 3'b101;
                    SRA:  begin f7 = F7_ALT; f3 = 3'b101; end
                    ORL:  f3 = 3'b110;
                    ANDL: f3 = 3'b111;
                    default: legal = 1'b0;
                endcase
            end
            MULT: begin
                f7 = F7_MULDIV;
                case (op)
                    MUL:    f3 = 3'b000;
                    MULH:   f3 = 3'b001;
                    MULHSU: f3 = 3'b010;
                    MULHU:  f3 = 3'b011;
                    DIV:    f3 = 3'b100;
                    DIVU:   f3 = 3'b101;
                    REM:    f3 = 3'b110;
                    REMU:   f3 = 3'b111;
                    default: legal = 1'b0;
                endcase
            end
            LOAD: begin
                opc = OPC_LOAD;
                case (op)
                    LB:  f3 = 3'b000;
                    LH:  f3 = 3'b001;
                    LW:  f3 = 3'b010;
                    LD:  f3 = 3'b011;
                    LBU: f3 = 3'b100;
                    LHU: f3 = 3'b101;
                    LWU: f3 = 3'b110;
                    default: legal = 1'b0;
                endcase
            end
            STORE: begin
                opc = OPC_STORE;
                case (op)
                    SB: f3 = 3'b000;
                    SH: f3 = 3'b001;
                    SW: f3 = 3'b010;
                    SD: f3 = 3'b011;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (!legal)
            e.instr = 32'h0000_0000;
        else if (opc == OPC_LOAD)
            e.instr = {imm, rs1, f3, rd, opc};
        else if (opc == OPC_STORE)
            e.instr = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
        else
            e.instr = {f7, rs2, rs1, f3, rd, opc};
        e.illegal = !legal;
        return e;
    endfunction

    logic       stage_valid_q, stage_valid_d;
    enc_entry_t stage_entry_q, stage_entry_d;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic       req_accept;
    enc_entry_t head;
    logic [CNT_W-1:0] enc_cnt_q, ill_cnt_q;

    assign fifo_pop    = !fifo_empty && instr_ready_i;
    // Ready only stalls when the stage has nowhere to go; a same-cycle pop frees a slot.
    assign req_ready_o = reset_n && !flush_i && !(stage_valid_q && fifo_full && !fifo_pop);
    assign req_accept  = req_valid_i && req_ready_o;
    assign fifo_push   = stage_valid_q && (!fifo_full || fifo_pop) && !flush_i;

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_entry_d = stage_entry_q;
        if (flush_i) begin
            stage_valid_d = 1'b0;
        end else if (req_accept) begin
            stage_valid_d = 1'b1;
            stage_entry_d = encode(req_fu_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, req_imm_i);
        end else if (fifo_push) begin
            stage_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid_q <= 1'b0;
            stage_entry_q <= '0;
            enc_cnt_q     <= '0;
            ill_cnt_q     <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_entry_q <= stage_entry_d;
            if (fifo_push) begin
                if (stage_entry_q.illegal) begin
                    if (ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + 1'b1;
                end else begin
                    if (enc_cnt_q != '1) enc_cnt_q <= enc_cnt_q + 1'b1;
                end
            end
        end
    end

    instr_enc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .entry_i (stage_entry_q),
        .pop_i   (fifo_pop),
        .entry_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head.instr;
    assign illegal_o     = head.illegal;
    assign enc_count_o   = enc_cnt_q;
    assign ill_count_o   = ill_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder: encodings, latency, back-pressure, flush, reset.
module tb_instr_encoder;
    import instr_enc_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush_i = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    fu_t              req_fu_i = NONE;
    fu_op             req_op_i = ADD;
    logic [4:0]       req_rs1_i = '0;
    logic [4:0]       req_rs2_i = '0;
    logic [4:0]       req_rd_i = '0;
    logic [11:0]      req_imm_i = '0;
    logic             instr_valid_o;
    logic             instr_ready_i = 1'b0;
    logic [31:0]      instr_o;
    logic             illegal_o;
    logic [CNT_W-1:0] enc_count_o;
    logic [CNT_W-1:0] ill_count_o;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_fu_i      (req_fu_i),
        .req_op_i      (req_op_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_rd_i      (req_rd_i),
        .req_imm_i     (req_imm_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .illegal_o     (illegal_o),
        .enc_count_o   (enc_count_o),
        .ill_count_o   (ill_count_o)
    );

    typedef struct {
        fu_t         fu;
        fu_op        op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] imm;
        logic [31:0] exp_instr;
        logic        exp_ill;
    } vec_t;

    int n_checks = 0;
    int n_errs   = 0;
    int exp_enc  = 0;
    int exp_ill  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        req_fu_i  = v.fu;
        req_op_i  = v.op;
        req_rs1_i = v.rs1;
        req_rs2_i = v.rs2;
        req_rd_i  = v.rd;
        req_imm_i = v.imm;
    endtask

    // Called just after a rising edge; returns just after the edge that pops the result.
    task automatic send_and_check(input vec_t v, input string nm);
        logic acc;
        acc = 1'b0;
        drive(v);
        req_valid_i   = 1'b1;
        instr_ready_i = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            if (req_ready_o) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        check({nm, " accept"}, {31'd0, acc}, 32'd1);
        @(negedge clk);
        check({nm, " valid@1"}, {31'd0, instr_valid_o}, 32'd0);
        @(negedge clk);
        if (v.exp_ill) exp_ill++; else exp_enc++;
        check({nm, " valid@2"}, {31'd0, instr_valid_o}, 32'd1);
        check({nm, " instr"}, instr_o, v.exp_instr);
        check({nm, " illegal"}, {31'd0, illegal_o}, {31'd0, v.exp_ill});
        check({nm, " enc_count"}, {16'd0, enc_count_o}, exp_enc);
        check({nm, " ill_count"}, {16'd0, ill_count_o}, exp_ill);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [13];
    vec_t bp   [4];

    initial begin
        int sent, got;
        logic acc_now, pop_now;

        vecs[0]  = '{ALU,   ADD,  5'd1,  5'd2,  5'd3,  12'h000, 32'h002081B3, 1'b0};
        vecs[1]  = '{ALU,   SUB,  5'd6,  5'd7,  5'd5,  12'h000, 32'h407302B3, 1'b0};
        vecs[2]  = '{MULT,  MUL,  5'd2,  5'd3,  5'd1,  12'h000, 32'h023100B3, 1'b0};
        vecs[3]  = '{LOAD,  LD,   5'd2,  5'd9,  5'd10, 12'hFF8, 32'hFF813503, 1'b0};
        vecs[4]  = '{STORE, SD,   5'd2,  5'd11, 5'd7,  12'h010, 32'h00B13823, 1'b0};
        vecs[5]  = '{ALU,   LB,   5'd1,  5'd2,  5'd3,  12'h000, 32'h00000000, 1'b1};
        vecs[6]  = '{ALU,   SRA,  5'd5,  5'd6,  5'd4,  12'h000, 32'h4062D233, 1'b0};
        vecs[7]  = '{MULT,  REMU, 5'd30, 5'd29, 5'd31, 12'h000, 32'h03DF7FB3, 1'b0};
        vecs[8]  = '{LOAD,  LBU,  5'd0,  5'd0,  5'd1,  12'h7FF, 32'h7FF04083, 1'b0};
        vecs[9]  = '{STORE, SB,   5'd3,  5'd4,  5'd0,  12'hFFF, 32'hFE418FA3, 1'b0};
        vecs[10] = '{MULT,  ADD,  5'd1,  5'd1,  5'd1,  12'h000, 32'h00000000, 1'b1};
        vecs[11] = '{STORE, LD,   5'd1,  5'd1,  5'd1,  12'h004, 32'h00000000, 1'b1};
        vecs[12] = '{ALU,   SLTU, 5'd8,  5'd9,  5'd10, 12'h000, 32'h00943533, 1'b0};

        bp[0] = '{ALU, ADD, 5'd1, 5'd2, 5'd1, 12'h000, 32'h002080B3, 1'b0};
        bp[1] = '{ALU, ADD, 5'd1, 5'd2, 5'd2, 12'h000, 32'h00208133, 1'b0};
        bp[2] = '{ALU, ADD, 5'd1, 5'd2, 5'd3, 12'h000, 32'h002081B3, 1'b0};
        bp[3] = '{ALU, ADD, 5'd1, 5'd2, 5'd4, 12'h000, 32'h00208233, 1'b0};

        // Reset state
        #2;
        check("rst valid",   {31'd0, instr_valid_o}, 32'd0);
        check("rst instr",   instr_o, 32'd0);
        check("rst illegal", {31'd0, illegal_o}, 32'd0);
        check("rst enc",     {16'd0, enc_count_o}, 32'd0);
        check("rst ill",     {16'd0, ill_count_o}, 32'd0);
        check("rst ready",   {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post-rst ready", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) send_and_check(vecs[i], $sformatf("v%0d", i));

        // Back-pressure: DEPTH+2 requests with the consumer stalled, then drain.
        instr_ready_i = 1'b0;
        sent = 0;
        got  = 0;
        drive(bp[0]);
        req_valid_i = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (c == 3 || c == 6) begin
                check($sformatf("bp c%0d ready low", c), {31'd0, req_ready_o}, 32'd0);
                check($sformatf("bp c%0d head", c), instr_o, bp[0].exp_instr);
                check($sformatf("bp c%0d sent", c), sent, 3);
            end
            acc_now = req_valid_i && req_ready_o;
            pop_now = instr_valid_o && instr_ready_i;
            if (pop_now) begin
                check($sformatf("bp drain %0d", got), instr_o, bp[got].exp_instr);
                got++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                sent++;
                if (sent < 4) drive(bp[sent]); else req_valid_i = 1'b0;
            end
            if (c == 7) instr_ready_i = 1'b1;
        end
        req_valid_i = 1'b0;
        exp_enc += 4;
        check("bp drained all", got, 4);
        @(negedge clk);
        check("bp empty after", {31'd0, instr_valid_o}, 32'd0);
        check("bp enc_count", {16'd0, enc_count_o}, exp_enc);
        @(posedge clk);
        #1;

        // Flush with FIFO full and stage occupied.
        instr_ready_i = 1'b0;
        sent = 0;
        drive(bp[0]);
        req_valid_i = 1'b1;
        for (int c = 0; c < 10 && sent < 3; c++) begin
            @(negedge clk);
            acc_now = req_ready_o;
            @(posedge clk);
            #1;
            if (acc_now) begin
                sent++;
                if (sent < 4) drive(bp[sent]);
            end
        end
        exp_enc += 2;
        check("fl filled", sent, 3);
        flush_i = 1'b1;
        @(negedge clk);
        check("fl ready low", {31'd0, req_ready_o}, 32'd0);
        check("fl head before", instr_o, bp[0].exp_instr);
        @(posedge clk);
        #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk);
        check("fl valid next", {31'd0, instr_valid_o}, 32'd0);
        check("fl enc kept", {16'd0, enc_count_o}, exp_enc);
        check("fl ill kept", {16'd0, ill_count_o}, exp_ill);
        repeat (2) @(negedge clk);
        check("fl stage cleared", {31'd0, instr_valid_o}, 32'd0);
        check("fl enc after", {16'd0, enc_count_o}, exp_enc);
        @(posedge clk);
        #1;

        // Async reset mid-stream.
        drive(bp[1]);
        req_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        check("ar pre valid", {31'd0, instr_valid_o}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar valid",   {31'd0, instr_valid_o}, 32'd0);
        check("ar instr",   instr_o, 32'd0);
        check("ar illegal", {31'd0, illegal_o}, 32'd0);
        check("ar enc",     {16'd0, enc_count_o}, 32'd0);
        check("ar ill",     {16'd0, ill_count_o}, 32'd0);
        check("ar ready",   {31'd0, req_ready_o}, 32'd0);
        #1;
        reset_n = 1'b1;
        #1;
        check("ar ready after", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        check("ar stage empty", {31'd0, instr_valid_o}, 32'd0);
        exp_enc = 0;
        exp_ill = 0;
        send_and_check(vecs[0], "ar add");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
